// File: rtl/bound_flasher_ctrl.sv
// Control FSM for the bound flasher: sequences the lamp counter through its
// up/down segments, handles kickback requests and the final blink phase.
module bound_flasher_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flick,
    input  logic [4:0]  counter,
    output logic [1:0]  count_state,
    output logic [4:0]  counter_load,
    output logic        counter_load_en,
    output logic [15:0] lamp
);

    localparam logic [1:0] COUNT_DIS     = 2'b00;
    localparam logic [1:0] COUNT_UP_EN   = 2'b01;
    localparam logic [1:0] COUNT_DOWN_EN = 2'b10;
    localparam logic [1:0] COUNT_HOLD    = 2'b11;
    localparam logic [4:0] COUNTER_INIT  = 5'd0;
    localparam logic [4:0] LAMP_MAX      = 5'd16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S2    = 3'd2,
        S3    = 3'd3,
        S4    = 3'd4,
        S5    = 3'd5,
        BLINK = 3'd6
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] blink_cnt;
    logic       kick_pt;

    assign kick_pt = flick && ((counter == 5'd6) || (counter == 5'd11));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = flick ? S1 : IDLE;
            S1:      if (counter == 5'd6) state_n = S2;
            S2:      if (counter == 5'd0) state_n = S3;
            S3: begin
                if (kick_pt)                state_n = S2;
                else if (counter == 5'd11)  state_n = S4;
            end
            S4:      if (counter == 5'd6) state_n = S5;
            S5: begin
                if (kick_pt)                state_n = S4;
                else if (counter == 5'd16)  state_n = BLINK;
            end
            BLINK: begin
                if ((blink_cnt == 2'd3) && (counter == COUNTER_INIT)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // blink_cnt counts the cycles that switch all lamps off while blinking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            blink_cnt <= 2'd0;
        end else begin
            state <= state_n;
            if (state_n == BLINK) begin
                if (counter != COUNTER_INIT) blink_cnt <= blink_cnt + 2'd1;
            end else begin
                blink_cnt <= 2'd0;
            end
        end
    end

    // Decoding from state_n lets the counter turn around on the target itself
    always_comb begin
        count_state     = COUNT_DIS;
        counter_load    = COUNTER_INIT;
        counter_load_en = 1'b0;
        if (rst_n) begin
            case (state_n)
                S1, S3, S5: count_state = COUNT_UP_EN;
                S2, S4:     count_state = COUNT_DOWN_EN;
                BLINK: begin
                    count_state     = COUNT_HOLD;
                    counter_load_en = 1'b1;
                    counter_load    = (counter == COUNTER_INIT) ? LAMP_MAX : COUNTER_INIT;
                end
                default:    count_state = COUNT_DIS;
            endcase
        end
    end

    always_comb begin
        lamp = '0;
        for (int i = 0; i < 16; i++) begin
            lamp[i] = (5'(i) < counter);
        end
    end

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Closed-loop bench for bound_flasher_ctrl: a next-counter stage feeds the
// counter back, and a phase/segment model predicts every cycle.
module tb_bound_flasher_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flick = 1'b0;
    logic [4:0]  counter = 5'd0;
    logic [1:0]  count_state;
    logic [4:0]  counter_load;
    logic        counter_load_en;
    logic [15:0] lamp;

    int checks = 0;
    int failures = 0;

    bound_flasher_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flick           (flick),
        .counter         (counter),
        .count_state     (count_state),
        .counter_load    (counter_load),
        .counter_load_en (counter_load_en),
        .lamp            (lamp)
    );

    always #5 clk = ~clk;

    // Next-counter stage (environment), deliberately without reset
    always @(posedge clk) begin
        if (counter_load_en) counter <= counter_load;
        else begin
            case (count_state)
                2'b00:   counter <= 5'd0;
                2'b01:   counter <= counter + 5'd1;
                2'b10:   counter <= counter - 5'd1;
                default: counter <= counter;
            endcase
        end
    end

    // Model: phase 0 idle, 1..5 are segments toward a target, 6 is blink
    int          m_phase = 0;
    int          m_cnt = 0;
    int          m_blinks = 0;
    int          e_pn;
    int          e_next;
    logic [1:0]  e_cs;
    logic [4:0]  e_load;
    logic        e_en;
    logic [15:0] e_lamp;

    function automatic int target(input int p);
        case (p)
            1: return 6;
            2: return 0;
            3: return 11;
            4: return 6;
            default: return 16;
        endcase
    endfunction

    function void model_eval(input logic f);
        int c;
        c = m_cnt;
        if (m_phase == 0) e_pn = f ? 1 : 0;
        else if (m_phase == 6) e_pn = (m_blinks == 3 && c == 0) ? 0 : 6;
        else if ((m_phase == 3 || m_phase == 5) && f && (c == 6 || c == 11)) e_pn = m_phase - 1;
        else if (c == target(m_phase)) e_pn = m_phase + 1;
        else e_pn = m_phase;
        e_en = 1'b0;
        e_load = 5'd0;
        if (e_pn == 0) begin
            e_cs = 2'b00;
            e_next = 0;
        end else if (e_pn == 6) begin
            e_cs = 2'b11;
            e_en = 1'b1;
            e_load = (c == 0) ? 5'd16 : 5'd0;
            e_next = int'(e_load);
        end else if (e_pn % 2 == 1) begin
            e_cs = 2'b01;
            e_next = (c + 1) % 32;
        end else begin
            e_cs = 2'b10;
            e_next = (c + 31) % 32;
        end
        e_lamp = (c >= 16) ? 16'hFFFF : 16'((32'd1 << c) - 32'd1);
    endfunction

    function void model_commit();
        if (e_pn == 6) begin
            if (m_cnt != 0) m_blinks++;
        end else begin
            m_blinks = 0;
        end
        m_phase = e_pn;
        m_cnt = e_next;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic test_reset();
        flick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (count_state !== 2'b00 || counter_load !== 5'd0 || counter_load_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs i=%0d got cs=%b load=%0d en=%b exp cs=00 load=0 en=0",
                         i, count_state, counter_load, counter_load_en);
            end
            @(negedge clk);
        end
        flick = 1'b0;
        rst_n = 1'b1;
        m_phase = 0; m_cnt = 0; m_blinks = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            model_eval(flick);
            checks++;
            if (count_state !== 2'b00 || lamp !== 16'h0000 || counter !== 5'd0 || counter_load_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle i=%0d got cs=%b lamp=%h cnt=%0d en=%b exp cs=00 lamp=0000 cnt=0 en=0",
                         i, count_state, lamp, counter, counter_load_en);
            end
            tick();
        end
    endtask

    task automatic test_full_sequence();
        int q[$];
        int tp[$];
        int n16 = 0;
        bit reached16 = 0;
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            flick = (i == 0);
            #1;
            model_eval(flick);
            checks++;
            if (count_state !== e_cs || counter_load !== e_load || counter_load_en !== e_en || counter !== 5'(m_cnt)) begin
                failures++;
                $display("FAIL full_seq i=%0d got cs=%b load=%0d en=%b cnt=%0d exp cs=%b load=%0d en=%b cnt=%0d",
                         i, count_state, counter_load, counter_load_en, counter, e_cs, e_load, e_en, m_cnt);
            end
            if (!reached16) q.push_back(int'(counter));
            if (counter == 5'd16) begin
                n16++;
                reached16 = 1;
                checks++;
                if (count_state === 2'b01) begin
                    failures++;
                    $display("FAIL up_at_16 i=%0d got cs=%b exp not 01", i, count_state);
                end
            end
            tick();
            if (i > 0 && m_phase == 0) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL full_seq_timeout got phase=%0d exp 0", m_phase);
        end
        for (int i = 1; i + 1 < q.size(); i++) begin
            if ((q[i] - q[i-1]) * (q[i+1] - q[i]) < 0) tp.push_back(q[i]);
        end
        if (q.size() > 0) tp.push_back(q[q.size()-1]);
        checks++;
        if (tp.size() != 5 || tp[0] != 6 || tp[1] != 0 || tp[2] != 11 || tp[3] != 6 || tp[4] != 16) begin
            failures++;
            $display("FAIL turning_points got n=%0d %p exp 6 0 11 6 16", tp.size(), tp);
        end
        checks++;
        if (n16 != 3) begin
            failures++;
            $display("FAIL blink_count got %0d cycles at 16 exp 3", n16);
        end
        checks++;
        if (counter !== 5'd0 || count_state !== 2'b00) begin
            failures++;
            $display("FAIL back_idle got cnt=%0d cs=%b exp cnt=0 cs=00", counter, count_state);
        end
    endtask

    task automatic test_kick_s3();
        bit kicked = 0, kick_now, saw0 = 0, saw11 = 0, done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            kick_now = !kicked && m_phase == 3 && m_cnt == 6;
            flick = (i == 0) || kick_now;
            #1;
            model_eval(flick);
            checks++;
            if (count_state !== e_cs || counter_load_en !== e_en || counter !== 5'(m_cnt)) begin
                failures++;
                $display("FAIL kick_s3_seq i=%0d got cs=%b en=%b cnt=%0d exp cs=%b en=%b cnt=%0d",
                         i, count_state, counter_load_en, counter, e_cs, e_en, m_cnt);
            end
            if (kick_now) begin
                checks++;
                if (count_state !== 2'b10) begin
                    failures++;
                    $display("FAIL kick_s3_dir got cs=%b exp 10", count_state);
                end
            end
            tick();
            if (kick_now) begin
                kicked = 1;
                checks++;
                if (counter !== 5'd5) begin
                    failures++;
                    $display("FAIL kick_s3_cnt got %0d exp 5", counter);
                end
            end
            if (kicked && counter == 5'd0) saw0 = 1;
            if (saw0 && counter == 5'd11) saw11 = 1;
            if (i > 0 && m_phase == 0) done = 1;
        end
        checks++;
        if (!done || !kicked || !saw0 || !saw11) begin
            failures++;
            $display("FAIL kick_s3_path got done=%0d kicked=%0d saw0=%0d saw11=%0d exp all 1",
                     done, kicked, saw0, saw11);
        end
    endtask

    task automatic test_kick_s5();
        bit kicked = 0, kick_now, saw6 = 0, saw16 = 0, done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            kick_now = !kicked && m_phase == 5 && m_cnt == 11;
            flick = (i == 0) || kick_now;
            #1;
            model_eval(flick);
            checks++;
            if (count_state !== e_cs || counter_load_en !== e_en || counter !== 5'(m_cnt)) begin
                failures++;
                $display("FAIL kick_s5_seq i=%0d got cs=%b en=%b cnt=%0d exp cs=%b en=%b cnt=%0d",
                         i, count_state, counter_load_en, counter, e_cs, e_en, m_cnt);
            end
            tick();
            if (kick_now) begin
                kicked = 1;
                checks++;
                if (counter !== 5'd10) begin
                    failures++;
                    $display("FAIL kick_s5_cnt got %0d exp 10", counter);
                end
            end
            if (kicked && counter == 5'd6) saw6 = 1;
            if (saw6 && counter == 5'd16) saw16 = 1;
            if (i > 0 && m_phase == 0) done = 1;
        end
        checks++;
        if (!done || !kicked || !saw6 || !saw16) begin
            failures++;
            $display("FAIL kick_s5_path got done=%0d kicked=%0d saw6=%0d saw16=%0d exp all 1",
                     done, kicked, saw6, saw16);
        end
    endtask

    task automatic test_s1_flick_held();
        bit held_done = 0, at_pt, done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            at_pt = !held_done && m_phase == 1 && m_cnt == 6;
            flick = !held_done;
            #1;
            model_eval(flick);
            checks++;
            if (count_state !== e_cs || counter !== 5'(m_cnt)) begin
                failures++;
                $display("FAIL s1_held_seq i=%0d got cs=%b cnt=%0d exp cs=%b cnt=%0d",
                         i, count_state, counter, e_cs, m_cnt);
            end
            tick();
            if (at_pt) begin
                held_done = 1;
                checks++;
                if (counter !== 5'd5) begin
                    failures++;
                    $display("FAIL s1_held_cnt got %0d exp 5", counter);
                end
            end
            if (i > 0 && m_phase == 0) done = 1;
        end
        checks++;
        if (!done || !held_done) begin
            failures++;
            $display("FAIL s1_held_timeout got done=%0d held=%0d exp 1 1", done, held_done);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_phase == 4 && m_cnt == 9) begin
                found = 1;
            end else begin
                flick = (i == 0);
                #1;
                model_eval(flick);
                tick();
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reset_mid_reach got phase=%0d cnt=%0d exp 4 9", m_phase, m_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (count_state !== 2'b00 || counter_load !== 5'd0 || counter_load_en !== 1'b0 || lamp !== 16'h01FF) begin
            failures++;
            $display("FAIL reset_mid_async got cs=%b load=%0d en=%b lamp=%h exp cs=00 load=0 en=0 lamp=01ff",
                     count_state, counter_load, counter_load_en, lamp);
        end
        rst_n = 1'b1;
        #1;
        m_phase = 0; m_blinks = 0;
        model_eval(flick);
        tick();
        checks++;
        if (counter !== 5'd0 || count_state !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_release got cnt=%0d cs=%b exp cnt=0 cs=00", counter, count_state);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            flick = ($urandom_range(0, 7) == 0);
            #1;
            model_eval(flick);
            checks++;
            if (count_state !== e_cs || counter_load !== e_load || counter_load_en !== e_en ||
                counter !== 5'(m_cnt) || lamp !== e_lamp) begin
                failures++;
                $display("FAIL random i=%0d got cs=%b load=%0d en=%b cnt=%0d lamp=%h exp cs=%b load=%0d en=%b cnt=%0d lamp=%h",
                         i, count_state, counter_load, counter_load_en, counter, lamp,
                         e_cs, e_load, e_en, m_cnt, e_lamp);
            end
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_sequence();
        test_kick_s3();
        test_kick_s5();
        test_s1_flick_held();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
